// File: rtl/spu_pkg.sv
// Shared definitions for the Mini SPU front end and execute core.
//   INSTR_W          : instruction width (two bytes, low byte first on the wire)
//   instr_t          : instruction word type
//   fetch_phase_t    : byte phase of the fetch assembler (PH_LO / PH_HI)
//   OPC_MSB/OPC_LSB  : opcode field bounds, decoded by the downstream core
package spu_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } fetch_phase_t;

    // Assemble an instruction from its two wire bytes.
    function automatic instr_t make_instr(input logic [7:0] hi_byte, input logic [7:0] lo_byte);
        return {hi_byte, lo_byte};
    endfunction

    // Extract the opcode field of an instruction.
    function automatic logic [OPC_MSB-OPC_LSB:0] instr_opcode(input instr_t instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/spu_sync_fifo.sv
// Small synchronous FIFO with registered read pointer.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of pointers and count (priority over push/pop)
//   push     : write wdata at the write pointer (caller guarantees !full or same-cycle pop)
//   pop      : advance the read pointer (caller guarantees !empty)
//   rdata    : storage entry at the registered read pointer
//   full/empty/count : occupancy status, count in 0..DEPTH
module spu_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Storage array; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push && !clr) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Read/write pointers; DEPTH is a power of two so they wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/spu_instr_fetch_buffer.sv
// Instruction fetch buffer: pairs loader bytes (LO then HI) into 16-bit
// instructions and queues them for the execute core.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid/in_data/in_ready : byte stream from the loader
//   flush      : synchronous drop of queued words and any held LO byte
//   out_valid/out_instr/out_ready : instruction handshake to the core
//   count      : queued words (0..DEPTH)
//   partial    : a LO byte is held waiting for its HI byte
module spu_instr_fetch_buffer
    import spu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [INSTR_W-1:0]     out_instr,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   partial
);

    fetch_phase_t phase_r;
    fetch_phase_t phase_nxt_s;
    logic [7:0]   lo_hold_r;
    logic         in_ready_s;
    logic         byte_acc_s;
    logic         push_s;
    logic         pop_s;
    logic         fifo_full_s;
    logic         fifo_empty_s;
    instr_t       fifo_rdata_s;

    // Byte acceptance: LO always fits; HI needs a free slot, which a
    // same-cycle pop provides. During flush the byte is taken and dropped.
    always_comb begin
        in_ready_s = 1'b1;
        if (flush) begin
            in_ready_s = 1'b1;
        end else if (phase_r == PH_HI) begin
            in_ready_s = !fifo_full_s || (out_valid && out_ready);
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign byte_acc_s = in_valid && in_ready_s && !flush;
    assign push_s     = byte_acc_s && (phase_r == PH_HI);
    assign pop_s      = out_valid && out_ready && !flush;

    // Phase next-state: each accepted byte toggles LO/HI; flush returns to LO.
    always_comb begin
        phase_nxt_s = phase_r;
        if (flush) begin
            phase_nxt_s = PH_LO;
        end else if (byte_acc_s) begin
            case (phase_r)
                PH_LO:   phase_nxt_s = PH_HI;
                PH_HI:   phase_nxt_s = PH_LO;
                default: phase_nxt_s = PH_LO;
            endcase
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Phase state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= PH_LO;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Low-byte holding register; a held byte is discarded on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_hold_r <= 8'h00;
        end else if (flush) begin
            lo_hold_r <= 8'h00;
        end else if (byte_acc_s && (phase_r == PH_LO)) begin
            lo_hold_r <= in_data;
        end
    end

    spu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (make_instr(in_data, lo_hold_r)),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (count)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = !fifo_empty_s;
    assign out_instr = fifo_rdata_s;
    assign partial   = (phase_r == PH_HI);

endmodule
